mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequencing arbiter that shares one single-ported, fixed-latency memory between the fetch stage (instruction reads) and the memory stage (data reads/writes). It accepts one request at a time, drives a single-cycle enable pulse to the memory, and counts the access latency. It returns read data with a one-cycle done pulse and produces per-port stall signals for the hazard logic. It sits between the fetch/memory pipeline stages and the shared memory instance.

## Interface
Parameters:
- LATENCY, 4, memory cycles from enable pulse to valid read data; legal range 1..15
- AW, 16, address width
- DW, 16, data width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held high with if_addr stable until if_done
- if_addr  in  AW  fetch address
- if_stall  out  1  if_req & ~if_done (combinational)
- if_done  out  1  one-cycle pulse: fetch access complete, rdata valid
- dm_req  in  1  data request; held with dm_wr/addr/wdata stable until dm_done
- dm_wr  in  1  1 = write, 0 = read
- dm_addr  in  AW  data address
- dm_wdata  in  DW  write data
- dm_stall  out  1  dm_req & ~dm_done (combinational)
- dm_done  out  1  one-cycle pulse: data access complete
- rdata  out  DW  registered read data, shared by both ports, held until the next read completes
- mem_en  out  1  one-cycle memory enable pulse
- mem_wr  out  1  write strobe, high only together with mem_en
- mem_addr  out  AW  latched address, held for the whole access
- mem_wdata  out  DW  latched write data
- mem_rdata  in  DW  memory read data
- busy  out  1  high in ISSUE and WAIT

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any request is high, grant one port (see Configuration). Latch addr, wr and wdata into the mem_* registers, then go to ISSUE. A write from the fetch port is impossible; fetch accesses are always reads.
- ISSUE: mem_en=1 and mem_wr=latched wr for this cycle only. Load the 4-bit counter with LATENCY-1. Go to WAIT, or go directly to DONE when LATENCY=1 and capture the data.
- WAIT: decrement the counter. When the counter reaches 0, capture mem_rdata into rdata (reads only) and go to DONE.
- DONE: pulse the granted port's done. Go to IDLE unconditionally. No request is accepted in DONE, because the served port's req is still high and stale.
- Writes: rdata is unchanged. Done timing is identical to reads.
- Dropping req mid-access is illegal. The arbiter completes the access anyway and the done pulse is ignored.
- Async reset (rst=0) from any state: IDLE immediately, access abandoned. All outputs go to 0: mem_en, mem_wr, mem_addr, mem_wdata, rdata, if_done, dm_done, busy. The stalls follow req.

## Timing
- Request sampled high in IDLE during cycle 0. ISSUE (mem_en=1) in cycle 1. mem_rdata is valid in cycle LATENCY and captured at the end of that cycle. done=1 and rdata valid in cycle LATENCY+1. IDLE in cycle LATENCY+2.
- Throughput: one access per LATENCY+2 cycles. Back-to-back requests are granted in cycle LATENCY+2.
- The losing port stays stalled with no side effects and is granted in the next IDLE.
- Stall deasserts in the same cycle as done, so the pipeline advances at the end of that cycle.

## Configuration
- ARB_ROUNDROBIN_EN defined: a last_grant register is kept, reset value = fetch. When both requests are high in IDLE, the port not granted last wins. A single requester always wins. last_grant updates on each grant.
- Not defined: fixed priority, data port always wins ties (the older instruction first). The last_grant register is absent.

## Test plan
- Fetch read, LATENCY=4, if_addr=0x0010, mem_rdata=0xBEEF in cycle 4 -> mem_en only in cycle 1, mem_addr=0x0010; if_done and rdata=0xBEEF in cycle 5; if_stall high cycles 0-4.
- Data write, dm_addr=0x0040, dm_wdata=0x1234 -> mem_en=mem_wr=1 in cycle 1 with mem_wdata=0x1234; dm_done in cycle 5; rdata unchanged.
- Both requests in cycle 0, macro off -> data served (dm_done cycle 5), fetch granted cycle 6, if_done cycle 11; repeated ties -> data always wins.
- Macro on, both requests held continuously -> grants alternate dm, if, dm, if. The first tie goes to dm because last_grant resets to fetch.
- rst low in cycle 3 of a read -> busy=0, rdata=0, no done pulse; after release, the held request restarts from IDLE with full latency.
- LATENCY=1 -> mem_en cycle 1, done cycle 2, next grant cycle 3.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between the fetch and data ports.
// Optional build macro ARB_ROUNDROBIN_EN: round-robin tie-break instead of data-first priority.
module mem_port_arbiter #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned AW      = 16,
    parameter int unsigned DW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_stall,
    output logic          if_done,
    input  logic          dm_req,
    input  logic          dm_wr,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_stall,
    output logic          dm_done,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          grant_dm_q, grant_dm_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          pick_dm;

`ifdef ARB_ROUNDROBIN_EN
    // grant_dm_q is also the last-grant record; it resets to fetch so the first tie goes to data.
    assign pick_dm = dm_req & (~if_req | ~grant_dm_q);
`else
    assign pick_dm = dm_req;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grant_dm_d = grant_dm_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (if_req | dm_req) begin
                    grant_dm_d = pick_dm;
                    addr_d     = pick_dm ? dm_addr : if_addr;
                    wr_d       = pick_dm & dm_wr;
                    if (pick_dm) begin
                        wdata_d = dm_wdata;
                    end
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d = 4'(LATENCY - 1);
                if (LATENCY == 1) begin
                    if (!wr_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = StDone;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    if (!wr_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = StDone;
                end
            end
            StDone: begin
                // Served port's req is still high here, so never re-arbitrate in this state.
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            grant_dm_q <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            grant_dm_q <= grant_dm_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
        end
    end

    assign mem_en    = (state_q == StIssue);
    assign mem_wr    = mem_en & wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;
    assign busy      = (state_q == StIssue) | (state_q == StWait);
    assign if_done   = (state_q == StDone) & ~grant_dm_q;
    assign dm_done   = (state_q == StDone) & grant_dm_q;
    assign if_stall  = if_req & ~if_done;
    assign dm_stall  = dm_req & ~dm_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a time-stamped reference model predicts each grant,
// memory access and done pulse; a separate monitor compares the DUT against those predictions.
module tb_mem_port_arbiter;

    localparam int          LAT = 4;
    localparam int unsigned AW  = 16;
    localparam int unsigned DW  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_stall, if_done;
    logic [AW-1:0] if_addr;
    logic          dm_req, dm_wr, dm_stall, dm_done;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] rdata;
    logic          mem_en, mem_wr, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    mem_port_arbiter #(
        .LATENCY(LAT),
        .AW     (AW),
        .DW     (DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_stall (if_stall),
        .if_done  (if_done),
        .dm_req   (dm_req),
        .dm_wr    (dm_wr),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_stall (dm_stall),
        .dm_done  (dm_done),
        .rdata    (rdata),
        .mem_en   (mem_en),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vecs = 0;
    int errs = 0;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] wdata;
    } issue_t;

    typedef struct {
        int            cyc;
        logic          dm;
        logic          rd;
        logic [DW-1:0] rdata;
    } done_t;

    issue_t        exp_issue[$];
    done_t         exp_done[$];
    logic [DW-1:0] mem[512];
    logic [DW-1:0] ref_mem[512];
    int            free_at = 0;
    logic          last_dm = 1'b0;
    int            busy_lo = 0;
    int            busy_hi = -1;
    logic [DW-1:0] mon_rdata = '0;
    int            en_cyc = -100;
    logic [AW-1:0] en_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory: data appears only in the cycle LAT-1 after mem_en; junk at all other times.
    always @(negedge clk) begin
        if (mem_en) begin
            if (mem_wr) mem[mem_addr[8:0]] = mem_wdata;
            en_cyc  = cyc;
            en_addr = mem_addr;
        end
        if (cyc == en_cyc + LAT - 1) mem_rdata = mem[en_addr[8:0]];
        else mem_rdata = 16'($urandom);
    end

    // Reference model: one access at a time, LAT+2 cycles each, decided from the request lines.
    always @(negedge clk) begin
        issue_t ie;
        done_t  de;
        logic   pick;
        if (!rst) begin
            exp_issue.delete();
            exp_done.delete();
            free_at = 0;
            last_dm = 1'b0;
            busy_lo = 0;
            busy_hi = -1;
        end else if (cyc >= free_at && (if_req || dm_req)) begin
`ifdef ARB_ROUNDROBIN_EN
            pick = dm_req && (!if_req || !last_dm);
`else
            pick = dm_req;
`endif
            last_dm  = pick;
            ie.cyc   = cyc + 1;
            ie.addr  = pick ? dm_addr : if_addr;
            ie.wr    = pick && dm_wr;
            ie.wdata = dm_wdata;
            de.cyc   = cyc + LAT + 1;
            de.dm    = pick;
            de.rd    = !ie.wr;
            de.rdata = ref_mem[ie.addr[8:0]];
            if (ie.wr) ref_mem[ie.addr[8:0]] = dm_wdata;
            exp_issue.push_back(ie);
            exp_done.push_back(de);
            busy_lo = cyc + 1;
            busy_hi = cyc + LAT;
            free_at = cyc + LAT + 2;
        end
    end

    // Monitor: compares every cycle against whatever the model queued for this cycle.
    always begin
        logic ei, ed, e_if, e_dm;
        @(negedge clk);
        #1;
        ei   = (exp_issue.size() > 0) && (exp_issue[0].cyc == cyc);
        ed   = (exp_done.size() > 0) && (exp_done[0].cyc == cyc);
        e_if = ed && !exp_done[0].dm;
        e_dm = ed && exp_done[0].dm;
        check("if_stall", 32'(if_stall), 32'(if_req & ~e_if));
        check("dm_stall", 32'(dm_stall), 32'(dm_req & ~e_dm));
        if (!rst) begin
            mon_rdata = '0;
            check("reset_ctrl", 32'({busy, mem_en, mem_wr, if_done, dm_done}), 32'(0));
            check("reset_regs", 32'({mem_addr, mem_wdata}), 32'(0));
        end else begin
            check("busy", 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
            check("mem_en", 32'(mem_en), 32'(ei));
            check("mem_wr", 32'(mem_wr), 32'(ei && exp_issue[0].wr));
            if (ei) begin
                check("mem_addr", 32'(mem_addr), 32'(exp_issue[0].addr));
                if (exp_issue[0].wr) check("mem_wdata", 32'(mem_wdata), 32'(exp_issue[0].wdata));
                void'(exp_issue.pop_front());
            end
            check("done", 32'({if_done, dm_done}), 32'({e_if, e_dm}));
            if (ed) begin
                if (exp_done[0].rd) mon_rdata = exp_done[0].rdata;
                void'(exp_done.pop_front());
            end
        end
        check("rdata", 32'(rdata), 32'(mon_rdata));
    end

    task automatic fetch_txn(input logic [AW-1:0] a, input int gap);
        int n = 0;
        if_addr = a;
        if_req  = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!if_done && n < 200);
        if (!if_done) begin
            vecs++;
            errs++;
            $display("FAIL fetch_timeout: no if_done within %0d cycles, expected a done pulse", n);
        end
        @(posedge clk);
        #1;
        if_req = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic dm_txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int gap);
        int n = 0;
        dm_wr    = wr;
        dm_addr  = a;
        dm_wdata = d;
        dm_req   = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!dm_done && n < 200);
        if (!dm_done) begin
            vecs++;
            errs++;
            $display("FAIL dm_timeout: no dm_done within %0d cycles, expected a done pulse", n);
        end
        @(posedge clk);
        #1;
        dm_req = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] v;
        rst      = 1'b0;
        if_req   = 1'b0;
        if_addr  = '0;
        dm_req   = 1'b0;
        dm_wr    = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;
        for (int i = 0; i < 512; i++) begin
            v          = 16'($urandom);
            mem[i]     = v;
            ref_mem[i] = v;
        end
        mem[16]     = 16'hBEEF;
        ref_mem[16] = 16'hBEEF;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        fetch_txn(16'h0010, 2);
        dm_txn(1'b1, 16'h0040, 16'h1234, 2);
        dm_txn(1'b0, 16'h0040, 16'h0000, 2);

        // Simultaneous requests, then sustained contention with back-to-back requests.
        fork
            fetch_txn(16'h0020, 2);
            dm_txn(1'b0, 16'h0030, 16'h0000, 2);
        join
        fork
            begin
                for (int i = 0; i < 4; i++) fetch_txn(AW'(i * 3), 0);
            end
            begin
                for (int i = 0; i < 4; i++) dm_txn(1'(i), AW'(100 + i), DW'(16'hA000 + i), 0);
            end
        join
        repeat (2) @(posedge clk);
        #1;

        // Reset in cycle 3 of a read; the held request must restart from scratch.
        fork
            fetch_txn(16'h0010, 2);
            begin
                repeat (3) @(posedge clk);
                #1 rst = 1'b0;
                @(posedge clk);
                #1 rst = 1'b1;
            end
        join

        fork
            begin
                for (int i = 0; i < 40; i++)
                    fetch_txn(AW'($urandom_range(0, 511)), int'($urandom_range(0, 3)));
            end
            begin
                for (int i = 0; i < 40; i++)
                    dm_txn(1'($urandom), AW'($urandom_range(0, 511)), DW'($urandom),
                           int'($urandom_range(0, 3)));
            end
        join
        repeat (5) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
